// File: rtl/inst_mem_responder.sv
// Small generic FIFO. Clear empties it but still takes a same-edge write.
// Latency: a write is visible at rd_dat the cycle after the write edge when empty.
// Backpressure: rd_rdy pops the head; the caller must not write while full.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop;

    function automatic logic [AW-1:0] ptr_nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_vld = (count != '0);
    assign rd_dat = store[rd_ptr];
    assign pop    = rd_vld && rd_rdy;

    // Pointer/count bookkeeping; clear restarts the queue, keeping a same-edge write.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            if (wr_vld) begin
                store[0] <= wr_dat;
                wr_ptr   <= ptr_nxt('0);
                count    <= CW'(1);
            end else begin
                wr_ptr <= '0;
                count  <= '0;
            end
        end else begin
            if (wr_vld) begin
                store[wr_ptr] <= wr_dat;
                wr_ptr        <= ptr_nxt(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_nxt(rd_ptr);
            count <= count + CW'(wr_vld) - CW'(pop);
        end
    end
endmodule

// Instruction memory that answers fetch requests with a 32-bit instruction or fault.
// Latency: LATENCY cycles from acceptance to resp_valid (1..4).
// Backpressure: two credits shared by the pipeline and the response FIFO gate req_ready.
module inst_mem_responder #(
    parameter logic [63:0] PC_START    = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_idx,
    input  logic [63:0] ld_data
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } rsp_t;

    logic [63:0] mem [DEPTH_WORDS];

    logic        accept;
    logic [63:0] addr_off;
    logic        acc_err;
    logic [AW-1:0] rd_idx;
    logic [63:0] rdata;
    rsp_t        acc_rsp;
    logic        ld_ok;

    logic        fifo_wr;
    rsp_t        fifo_wdat;
    rsp_t        fifo_rdat;
    logic [1:0]  fifo_cnt;
    logic [2:0]  inflight;

    assign accept    = req_valid && req_ready;
    assign req_ready = (4'(inflight) + 4'(fifo_cnt)) < 4'd2;
    assign ld_ok     = ({32'd0, ld_idx} < 64'(DEPTH_WORDS));

    // Preload port: runs regardless of fetch traffic; out-of-range indices are dropped.
    always_ff @(posedge clock) begin
        if (ld_en && ld_ok) mem[AW'(ld_idx)] <= ld_data;
    end

    // Decode the request address in full 64-bit width so huge offsets cannot alias,
    // and read memory only for legal addresses.
    always_comb begin
        addr_off = req_addr - PC_START;
        acc_err  = (req_addr[1:0] != 2'b00) || (req_addr < PC_START)
                || ((addr_off >> 3) >= 64'(DEPTH_WORDS));
        rd_idx   = AW'(addr_off >> 3);
        rdata    = '0;
        if (!acc_err) rdata = mem[rd_idx];
        acc_rsp.err  = acc_err;
        acc_rsp.inst = acc_err ? NOP_INST
                     : (req_addr[2] ? rdata[63:32] : rdata[31:0]);
    end

    if (LATENCY == 1) begin : g_direct
        assign fifo_wr   = accept;
        assign fifo_wdat = acc_rsp;
        assign inflight  = '0;
    end else begin : g_pipe
        localparam int NSTG = LATENCY - 1;
        logic [NSTG-1:0] stg_vld;
        rsp_t            stg_dat [NSTG];

        // Delay line; flush kills old slots but a same-edge accept enters stage 0.
        always_ff @(posedge clock or negedge rst) begin
            if (!rst) begin
                stg_vld <= '0;
                for (int i = 0; i < NSTG; i++) stg_dat[i] <= '0;
            end else begin
                stg_vld[0] <= accept;
                stg_dat[0] <= acc_rsp;
                for (int i = 1; i < NSTG; i++) begin
                    stg_vld[i] <= stg_vld[i-1] && !flush;
                    stg_dat[i] <= stg_dat[i-1];
                end
            end
        end

        assign fifo_wr   = stg_vld[NSTG-1] && !flush;
        assign fifo_wdat = stg_dat[NSTG-1];
        assign inflight  = 3'($countones(stg_vld));
    end

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(2)) u_rsp_fifo (
        .clock  (clock),
        .rst    (rst),
        .clr    (flush),
        .wr_vld (fifo_wr),
        .wr_dat (fifo_wdat),
        .rd_vld (resp_valid),
        .rd_rdy (resp_ready),
        .rd_dat (fifo_rdat),
        .count  (fifo_cnt)
    );

    assign resp_inst = fifo_rdat.inst;
    assign resp_err  = fifo_rdat.err;
endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: queue-based reference model plus directed scenarios.
// Latency: model tracks each accepted fetch by the edge it lands in the response queue.
// Backpressure: model derives req_ready from its own outstanding count.
module tb_inst_mem_responder;
    localparam logic [63:0] PC    = 64'h8000_0000;
    localparam longint      DEPTH = 4096;
    localparam int          LAT   = 2;

    logic        clock;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_idx;
    logic [63:0] ld_data;

    inst_mem_responder #(.PC_START(PC), .DEPTH_WORDS(4096), .LATENCY(LAT)) dut (
        .clock      (clock),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_err   (resp_err),
        .flush      (flush),
        .ld_en      (ld_en),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic run_chk = 1'b0;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned due;
        logic [32:0] r;
    } pend_t;

    logic [63:0] mdl_mem [longint];
    pend_t       pend [$];
    logic [32:0] q [$];
    logic [32:0] got [$];
    int unsigned ecnt = 0;

    function automatic logic [32:0] mdl_rsp(input logic [63:0] a);
        logic [63:0] w;
        longint idx;
        if ((a % 4) != 0 || a < PC || ((a - PC) / 8) >= 64'(DEPTH))
            return {1'b1, 32'h0000_0013};
        idx = longint'((a - PC) / 8);
        w = mdl_mem.exists(idx) ? mdl_mem[idx] : 64'h0;
        return {1'b0, ((a % 8) >= 4) ? w[63:32] : w[31:0]};
    endfunction

    function automatic logic mdl_rdy();
        return (pend.size() + q.size()) < 2;
    endfunction

    task automatic model_step();
        logic acc;
        logic [32:0] nr;
        pend_t p;
        if (!rst) begin
            pend.delete();
            q.delete();
        end else begin
            acc = req_valid && mdl_rdy();
            nr  = mdl_rsp(req_addr);
            if (flush) begin
                pend.delete();
                q.delete();
            end else if (q.size() > 0 && resp_ready) begin
                void'(q.pop_front());
            end
            if (acc) begin
                p.due = ecnt + LAT - 1;
                p.r   = nr;
                pend.push_back(p);
            end
            while (pend.size() > 0 && pend[0].due == ecnt) begin
                p = pend.pop_front();
                q.push_back(p.r);
            end
            if (ld_en && ({32'd0, ld_idx} < 64'(DEPTH))) mdl_mem[longint'(ld_idx)] = ld_data;
            ecnt++;
        end
    endtask

    always @(posedge clock or negedge rst) model_step();

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (run_chk) begin
            chk("req_ready", 64'(req_ready), 64'(mdl_rdy()));
            chk("resp_valid", 64'(resp_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("resp_inst", 64'(resp_inst), 64'(q[0][31:0]));
                chk("resp_err", 64'(resp_err), 64'(q[0][32]));
            end
            if (rst && resp_valid && resp_ready) got.push_back({resp_err, resp_inst});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic load(input logic [31:0] idx, input logic [63:0] d);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic send(input logic [63:0] a);
        int n;
        n = 0;
        req_valid = 1'b1; req_addr = a;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_accept", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        flush = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_inst", 64'(resp_inst), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        run_chk = 1'b1;
        repeat (2) @(posedge clock);
        #2 rst = 1'b1;
        step();

        // Scenario 1: two halves of word 0, in order.
        load(0, 64'hAAAA_BBBB_1111_2222);
        resp_ready = 1'b1; got.delete();
        req_valid = 1'b1; req_addr = 64'h8000_0000;
        step();
        chk("s1_valid_after_accept", 64'(resp_valid), 64'd0);
        req_addr = 64'h8000_0004;
        step();
        chk("s1_valid_next", 64'(resp_valid), 64'd1);
        chk("s1_inst_next", 64'(resp_inst), 64'h1111_2222);
        req_valid = 1'b0;
        drain();
        chk("s1_count", 64'(got.size()), 64'd2);
        chk("s1_r0", 64'(got[0]), {31'd0, 1'b0, 32'h1111_2222});
        chk("s1_r1", 64'(got[1]), {31'd0, 1'b0, 32'hAAAA_BBBB});

        // Scenario 2: backpressure with three back-to-back requests.
        resp_ready = 1'b0; got.delete();
        req_valid = 1'b1; req_addr = 64'h8000_0000; step();
        req_addr = 64'h8000_0004; step();
        req_addr = 64'h8000_0000; step();
        step();
        chk("s2_ready_low", 64'(req_ready), 64'd0);
        chk("s2_valid", 64'(resp_valid), 64'd1);
        chk("s2_head", 64'(resp_inst), 64'h1111_2222);
        step(); step();
        chk("s2_head_stable", 64'(resp_inst), 64'h1111_2222);
        chk("s2_ready_still_low", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!req_ready && n < 20) begin step(); n++; end
        end
        chk("s2_ready_back", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        drain();
        chk("s2_count", 64'(got.size()), 64'd3);
        chk("s2_r0", 64'(got[0]), 64'h1111_2222);
        chk("s2_r1", 64'(got[1]), 64'hAAAA_BBBB);
        chk("s2_r2", 64'(got[2]), 64'h1111_2222);

        // Scenario 3: faulting addresses and the last legal word.
        load(4095, 64'h0123_4567_89AB_CDEF);
        got.delete();
        send(64'h8000_0002);
        send(64'h7FFF_FFFC);
        send(PC + 64'd32768);
        send(64'hFFFF_FFFF_FFFF_FFF8);
        send(64'h8000_7FFC);
        drain();
        chk("s3_count", 64'(got.size()), 64'd5);
        chk("s3_misaligned", 64'(got[0]), {31'd0, 1'b1, 32'h0000_0013});
        chk("s3_below", 64'(got[1]), {31'd0, 1'b1, 32'h0000_0013});
        chk("s3_past_end", 64'(got[2]), {31'd0, 1'b1, 32'h0000_0013});
        chk("s3_wrap", 64'(got[3]), {31'd0, 1'b1, 32'h0000_0013});
        chk("s3_last_word", 64'(got[4]), 64'h0123_4567);

        // Scenario 4: flush discards outstanding work, keeps a same-edge request.
        load(2, 64'h5555_6666_7777_8888);
        resp_ready = 1'b0; got.delete();
        send(64'h8000_0000);
        send(64'h8000_0004);
        step(); step();
        chk("s4_full_valid", 64'(resp_valid), 64'd1);
        flush = 1'b1; step(); flush = 1'b0;
        chk("s4_flush_clears", 64'(resp_valid), 64'd0);
        send(64'h8000_0008);
        req_valid = 1'b1; req_addr = 64'h8000_0010; flush = 1'b1;
        chk("s4_ready_at_flush", 64'(req_ready), 64'd1);
        step();
        flush = 1'b0; req_valid = 1'b0;
        chk("s4_valid_after_flush", 64'(resp_valid), 64'd0);
        resp_ready = 1'b1;
        drain();
        chk("s4_count", 64'(got.size()), 64'd1);
        chk("s4_r0", 64'(got[0]), 64'h7777_8888);

        // Scenario 5: load and read of the same word at one edge.
        got.delete();
        ld_en = 1'b1; ld_idx = 0; ld_data = 64'h9999_0000_1234_5678;
        req_valid = 1'b1; req_addr = 64'h8000_0000;
        step();
        ld_en = 1'b0; req_valid = 1'b0;
        send(64'h8000_0000);
        load(4096, 64'hDEAD_BEEF_DEAD_BEEF);
        send(64'h8000_0004);
        drain();
        chk("s5_count", 64'(got.size()), 64'd3);
        chk("s5_old", 64'(got[0]), 64'h1111_2222);
        chk("s5_new", 64'(got[1]), 64'h1234_5678);
        chk("s5_oob_load_ignored", 64'(got[2]), 64'h9999_0000);

        // Scenario 6: asynchronous reset with a full FIFO.
        resp_ready = 1'b0; got.delete();
        send(64'h8000_0000);
        send(64'h8000_0004);
        step(); step();
        chk("s6_full_valid", 64'(resp_valid), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("s6_async_valid", 64'(resp_valid), 64'd0);
        chk("s6_async_inst", 64'(resp_inst), 64'd0);
        chk("s6_async_err", 64'(resp_err), 64'd0);
        chk("s6_async_ready", 64'(req_ready), 64'd1);
        step(); step();
        rst = 1'b1;
        resp_ready = 1'b1;
        drain();
        chk("s6_no_stale", 64'(got.size()), 64'd0);
        send(64'h8000_0000);
        drain();
        chk("s6_mem_kept_count", 64'(got.size()), 64'd1);
        chk("s6_mem_kept", 64'(got[0]), 64'h1234_5678);

        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_mem_responder.md
INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 The parameter PC_START SHALL default to 64'h8000_0000 and SHALL be the byte address of memory word 0.
REQ-002 The parameter DEPTH_WORDS SHALL default to 4096 and SHALL be the number of 64-bit memory words.
REQ-003 The parameter LATENCY SHALL default to 2 and SHALL be the request-to-response latency in cycles, legal range 1..4.
REQ-004 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port clock SHALL be input, width 1, the single clock; all state changes on its rising edge.
REQ-006 Port rst SHALL be input, width 1, the asynchronous active-low reset.
REQ-007 Port req_valid SHALL be input, width 1, fetch request present.
REQ-008 Port req_ready SHALL be output, width 1, the responder accepts a request this cycle.
REQ-009 Port req_addr SHALL be input, width 64, the fetch byte address (PC).
REQ-010 Port resp_valid SHALL be output, width 1, the response is present.
REQ-011 Port resp_ready SHALL be input, width 1, the fetcher accepts the response.
REQ-012 Port resp_inst SHALL be output, width 32, the instruction word.
REQ-013 Port resp_err SHALL be output, width 1, the access fault flag.
REQ-014 Port flush SHALL be input, width 1, discard all outstanding work on jump/branch.
REQ-015 Port ld_en SHALL be input, width 1, preload write strobe.
REQ-016 Port ld_idx SHALL be input, width 32, preload word index.
REQ-017 Port ld_data SHALL be input, width 64, preload word data.

Function
REQ-018 A request SHALL be accepted at a rising edge E where req_valid && req_ready.
REQ-019 req_ready SHALL equal (inflight + fifo_count) < 2, and SHALL NOT depend combinationally on req_valid or resp_ready.
REQ-020 The accepted request SHALL have word index = (req_addr - PC_START) >> 3.
REQ-021 The accepted request SHALL sample memory at edge E, returning old data even if ld_en writes the same word at E.
REQ-022 resp_inst SHALL be rdata[63:32] when req_addr[2]=1, else rdata[31:0].
REQ-023 resp_err SHALL be 1 and resp_inst SHALL be 32'h0000_0013 when req_addr[1:0]!=0, req_addr<PC_START, or the index >= DEPTH_WORDS; memory SHALL NOT be read in that case.
REQ-024 The response SHALL be written into a 2-entry FIFO at edge E+LATENCY-1, so resp_valid=1 in the cycle after that edge when the FIFO was empty; LATENCY=1 gives a response in the cycle immediately after acceptance.
REQ-025 Responses SHALL leave in acceptance order, and the FIFO head SHALL pop at any edge with resp_valid && resp_ready.
REQ-026 resp_inst and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-027 A FIFO write and a FIFO pop at the same edge SHALL both take effect, with count unchanged.
REQ-028 The 2-credit rule SHALL guarantee the FIFO never overflows, and a response reaching the FIFO SHALL never be dropped or stalled.
REQ-029 flush=1 at an edge SHALL clear inflight and the FIFO and cancel pending pipeline slots; resp_valid SHALL be 0 the next cycle.
REQ-030 A request accepted at the same edge as flush=1 SHALL be kept as the first request of the new stream.
REQ-031 ld_en=1 SHALL write ld_data to word ld_idx at the edge; an ld_idx >= DEPTH_WORDS SHALL be ignored.
REQ-032 Loads SHALL be independent of the request/response handshake.
REQ-033 All address arithmetic SHALL be 64-bit unsigned; the index compare SHALL be made before truncation to avoid wrap-around aliasing.

Reset
REQ-034 rst low SHALL asynchronously clear inflight, fifo_count, the pipeline valid bits, resp_valid=0, resp_err=0, and resp_inst=0.
REQ-035 req_ready SHALL be 1 after reset deassertion.
REQ-036 Memory contents SHALL NOT be affected by reset.
REQ-037 Reset mid-transaction SHALL drop all outstanding responses, and no stale response SHALL appear after release.

Verification
REQ-038 Scenario 1: preload word0=64'hAAAA_BBBB_1111_2222, LATENCY=2, request 0x8000_0000 then 0x8000_0004 with resp_ready=1 -> 32'h1111_2222, then 32'hAAAA_BBBB, in order, err=0, first resp_valid 2 cycles after first accept.
REQ-039 Scenario 2: hold resp_ready=0, issue 3 back-to-back requests -> req_ready drops after 2 accepts, FIFO holds 2 stable responses; raise resp_ready -> both drain, then the third is accepted.
REQ-040 Scenario 3: requests 0x8000_0002, 0x7FFF_FFFC, and PC_START+8*4096 -> each gives resp_err=1 with resp_inst=32'h0000_0013.
REQ-041 Scenario 4: two requests outstanding, flush with a new request 0x8000_0010 at the same edge -> only the 0x8000_0010 response appears.
REQ-042 Scenario 5: ld_en writes word0 at the same edge a request for word0 is accepted -> old data returned; next request returns new data.
REQ-043 Scenario 6: assert rst with a full FIFO asynchronously mid-cycle -> resp_valid=0 immediately; after release, no response without a new request.
